// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, coefficients and FSM state type for the serial
// all-pole IIR section (pole_serial and its pole_mac datapath).
package iir_pkg;

  localparam int XIN_W     = 21;  // zero-section output, Q0 integer
  localparam int Y_W       = 12;  // filter output / history width
  localparam int ACC_W     = 36;  // MAC accumulator width
  localparam int COEF_W    = 12;  // nominal Q11 coefficient width
  localparam int FRAC      = 11;  // coefficient fraction bits
  localparam int OUT_SHIFT = 19;  // accumulator -> output scaling
  localparam int N_POLE    = 6;   // number of feedback taps

  // A1 (-2662) and A2 (2458) lie outside the 12-bit Q11 range, so the
  // stored coefficients carry one extra integer bit to keep their values.
  localparam int COEF_HW   = COEF_W + 1;
  // Each product is pre-scaled so that the final >>> OUT_SHIFT lines up
  // with Xin <<< FRAC.
  localparam int MAC_SHIFT = OUT_SHIFT - FRAC;
  localparam int K_W       = 3;   // tap counter width, holds 0..7

  localparam logic signed [COEF_HW-1:0] A1 = -13'sd2662;
  localparam logic signed [COEF_HW-1:0] A2 =  13'sd2458;
  localparam logic signed [COEF_HW-1:0] A3 = -13'sd1229;
  localparam logic signed [COEF_HW-1:0] A4 =  13'sd410;
  localparam logic signed [COEF_HW-1:0] A5 = -13'sd82;
  localparam logic signed [COEF_HW-1:0] A6 =  13'sd8;

  // Output limits, and the accumulator values at which floor(acc/2^19)
  // leaves the 12-bit range.
  localparam logic signed [Y_W-1:0]   Y_MAX   = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0]   Y_MIN   = {1'b1, {(Y_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_HI  = ACC_W'(1) << (Y_W - 1 + OUT_SHIFT);
  localparam logic signed [ACC_W-1:0] ACC_LO  = -ACC_HI;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_t;

  // Coefficient for tap k (1..6); other counter values select zero.
  function automatic logic signed [COEF_HW-1:0] coef_of(input logic [K_W-1:0] k);
    case (k)
      3'd1:    return A1;
      3'd2:    return A2;
      3'd3:    return A3;
      3'd4:    return A4;
      3'd5:    return A5;
      3'd6:    return A6;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pole_mac.sv
// pole_mac: one combinational feedback step,
//   acc_next = acc - ((coef * y) <<< MAC_SHIFT), all signed.
// Ports:
//   acc      in  ACC_W   current accumulator
//   coef     in  COEF_HW tap coefficient (Q11)
//   y        in  Y_W     past output for this tap
//   acc_next out ACC_W   accumulator after subtracting the term
module pole_mac
  import iir_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [COEF_HW-1:0] coef,
  input  logic signed [Y_W-1:0]     y,
  output logic signed [ACC_W-1:0]   acc_next
);

  localparam int PROD_W = COEF_HW + Y_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;

  always_comb begin
    prod     = coef * y;
    term     = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} <<< MAC_SHIFT;
    acc_next = acc - term;
  end

endmodule

// File: rtl/pole_serial.sv
// pole_serial: serial 6-pole all-pole IIR section, one sample per 8 clocks.
//   y[n] = ((Xin <<< 11) - sum_k ((A_k * y[n-k]) <<< 8)) >>> 19
// Sequence: IDLE (accept) -> 6 x MAC (taps 1..6) -> DONE (convert, shift
// history, pulse out_valid) -> IDLE.
// Ports:
//   clk       in   sole clock
//   rst       in   synchronous active-high reset
//   Xin       in   21-bit signed sample
//   in_valid  in   Xin valid this cycle
//   in_ready  out  high only in IDLE
//   Yout      out  12-bit signed registered result, held between updates
//   out_valid out  one-cycle pulse when Yout updates
// Build option: define POLE_SERIAL_SAT_EN to saturate the result to
// +2047/-2048; otherwise it wraps to its low 12 bits.
module pole_serial
  import iir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [XIN_W-1:0] Xin,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [Y_W-1:0]   Yout,
  output logic                    out_valid
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, mac_acc_next;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [Y_W-1:0]    hist_q [N_POLE];  // hist_q[0] = y[n-1]
  logic signed [Y_W-1:0]    hist_d [N_POLE];
  logic signed [Y_W-1:0]    yout_q, yout_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [Y_W-1:0]    y_tap, y_conv;
  logic signed [COEF_HW-1:0] coef_k;

  // Operands for the current tap k (k = 1 selects y[n-1]).
  always_comb begin
    y_tap  = '0;
    coef_k = coef_of(k_q);
    for (int i = 0; i < N_POLE; i++) begin
      if (k_q == K_W'(i + 1)) y_tap = hist_q[i];
    end
  end

  pole_mac u_mac (
    .acc      (acc_q),
    .coef     (coef_k),
    .y        (y_tap),
    .acc_next (mac_acc_next)
  );

  // Bits [OUT_SHIFT +: Y_W] of the accumulator are exactly the low 12 bits
  // of acc >>> OUT_SHIFT, so no wide shifter is needed.
  always_comb begin
`ifdef POLE_SERIAL_SAT_EN
    if (acc_q >= ACC_HI)     y_conv = Y_MAX;
    else if (acc_q < ACC_LO) y_conv = Y_MIN;
    else                     y_conv = acc_q[OUT_SHIFT +: Y_W];
`else
    y_conv = acc_q[OUT_SHIFT +: Y_W];
`endif
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    hist_d      = hist_q;
    yout_d      = yout_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = {{(ACC_W - XIN_W){Xin[XIN_W-1]}}, Xin} <<< FRAC;
          k_d     = K_W'(1);
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = mac_acc_next;
        k_d   = k_q + K_W'(1);
        if (k_q == K_W'(N_POLE)) state_d = ST_DONE;
      end
      ST_DONE: begin
        yout_d      = y_conv;
        hist_d[0]   = y_conv;
        for (int i = 1; i < N_POLE; i++) hist_d[i] = hist_q[i-1];
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      yout_q      <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the history is small and feeds the recursion from the first
      // sample, so it is cleared explicitly rather than left uninitialised.
      for (int i = 0; i < N_POLE; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      yout_q      <= yout_d;
      out_valid_q <= out_valid_d;
      hist_q      <= hist_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign Yout      = yout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pole_serial.sv
// tb_pole_serial: directed bench for pole_serial with an arithmetic
// reference model of the recursion and an every-cycle compare process.
module tb_pole_serial;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [20:0] Xin = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] Yout;
  logic               out_valid;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  pole_serial dut (
    .clk       (clk),
    .rst       (rst),
    .Xin       (Xin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Yout      (Yout),
    .out_valid (out_valid)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int a_coef [1:6] = '{-2662, 2458, -1229, 410, -82, 8};
  int mh [1:6];          // mh[k] = y[n-k]
  int m_cnt     = -1;    // edges since acceptance, -1 when idle
  int m_x       = 0;
  int exp_y     = 0;
  bit exp_valid = 1'b0;
  bit exp_ready = 1'b1;

  function automatic int model_y(input int x);
    longint acc;
    longint q;
    int     w;
    acc = longint'(x) * 2048;
    for (int k = 1; k <= 6; k++) acc -= longint'(a_coef[k]) * longint'(mh[k]) * 256;
    q = acc >>> 19;  // floor division by 2^19
`ifdef POLE_SERIAL_SAT_EN
    if (q > 2047)       w = 2047;
    else if (q < -2048) w = -2048;
    else                w = int'(q);
`else
    w = int'(q & 64'hFFF);
    if (w >= 2048) w -= 4096;
`endif
    return w;
  endfunction

  initial begin
    for (int k = 1; k <= 6; k++) mh[k] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 1; k <= 6; k++) mh[k] = 0;
        m_cnt = -1; exp_y = 0; exp_valid = 1'b0; exp_ready = 1'b1;
      end else begin
        exp_valid = 1'b0;
        if (m_cnt >= 0) begin
          m_cnt++;
          // Result launched on the 7th edge after acceptance, so it is
          // seen by a consumer at the 8th edge.
          if (m_cnt == 7) begin
            exp_y = model_y(m_x);
            for (int k = 6; k > 1; k--) mh[k] = mh[k-1];
            mh[1] = exp_y;
            exp_valid = 1'b1;
            m_cnt = -1;
          end
        end else if (in_valid) begin
          m_x   = int'(Xin);
          m_cnt = 0;
        end
        exp_ready = (m_cnt < 0);
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #2;
    if (armed) begin
      check("cyc_in_ready", int'(in_ready), int'(exp_ready));
      check("cyc_out_valid", int'(out_valid), int'(exp_valid));
      check("cyc_yout", int'(Yout), exp_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Present one sample and wait (bounded) for its result; lat is the edge
  // count from acceptance to the edge that first sees out_valid high.
  task automatic send(input int x, output int y, output int lat);
    @(negedge clk); Xin = 21'(x); in_valid = 1'b1;
    @(posedge clk); #2; in_valid = 1'b0;
    lat = 0; y = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #2;
      if (out_valid) begin
        lat = e + 1;
        y   = int'(Yout);
        break;
      end
    end
  endtask

  int y, lat, pulses;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    @(posedge clk); #2;
    check("reset_yout", int'(Yout), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);

    send(25600, y, lat);
    check("step_yout", y, 100);
    check("step_latency", lat, 8);
    send(0, y, lat);
    check("after_step_yout", y, 129);

    do_reset();
    send(1048575, y, lat);
`ifdef POLE_SERIAL_SAT_EN
    check("overflow_yout", y, 2047);
`else
    check("overflow_yout", y, -1);
`endif

    // Reset wins over a simultaneous in_valid.
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; Xin = 21'(25600);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #2;
    check("rst_prio_ready", int'(in_ready), 1);
    check("rst_prio_yout", int'(Yout), 0);
    repeat (10) @(posedge clk);

    // in_valid held high: one acceptance per 8 cycles, others dropped.
    @(negedge clk); in_valid = 1'b1; Xin = 21'(300); pulses = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #2;
      if (out_valid) pulses++;
      Xin = 21'(1000 * (i + 1));
    end
    in_valid = 1'b0;
    check("continuous_pulses", pulses, 4);

    // Reset three edges after acceptance aborts the sample.
    do_reset();
    @(negedge clk); Xin = 21'(25600); in_valid = 1'b1;
    @(posedge clk); #2; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_yout", int'(Yout), 0);
    send(25600, y, lat);
    check("abort_then_step", y, 100);

    // Unit impulse then 64 zeros.
    do_reset();
    send(2048, y, lat);
    check("impulse_y0", y, 8);
    send(0, y, lat);
    check("impulse_y1", y, 10);
    for (int i = 0; i < 63; i++) send(0, y, lat);

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
